// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: parameter legality
// checks, saturation limits and the signed-overflow rule.
package addsub_pkg;

  localparam int MIN_WIDTH  = 8;
  localparam int MAX_WIDTH  = 64;
  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 4;

  // True when the width/stage combination can be built as equal carry slices.
  function automatic bit params_ok(input int width, input int stages);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
           (stages >= MIN_STAGES) && (stages <= MAX_STAGES) &&
           ((width % stages) == 0);
  endfunction

  // Largest positive two's-complement value of the given width, zero-extended.
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of the given width, zero-extended.
  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // Overflow: operands agree in sign but the raw result does not.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One registered carry slice. Adds bits [IDX*SW +: SW] of a and effective b
// with the incoming carry, merges them into the travelling partial sum and
// forwards operands, mode bits and carry to the next stage. The last slice
// also resolves overflow and saturation before its register.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             up_sub,
  input  logic             up_sat,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic             dn_sub,
  output logic             dn_sat,
  output logic [WIDTH-1:0] dn_sum,
  output logic             dn_carry,
  output logic             dn_ovf
);

  localparam int  SW   = WIDTH / STAGES;
  localparam int  LO   = IDX * SW;
  localparam bit  LAST = (IDX == STAGES - 1);
  localparam logic [63:0]      SAT_MAX64 = sat_max(WIDTH);
  localparam logic [63:0]      SAT_MIN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN64[WIDTH-1:0];

  logic [WIDTH-1:0] eb_s;
  logic [SW:0]      part_s;
  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] sum_nx_s;
  logic             ovf_s;
  logic             load_s;

  logic             valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             sat_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;

  // The slice can take a beat when empty or when its current beat moves on.
  assign up_ready = !valid_r || dn_ready;
  assign load_s   = up_valid && up_ready;

  // Partial add of this slice, then overflow/saturation in the final slice.
  always_comb begin
    eb_s   = up_b ^ {WIDTH{up_sub}};
    part_s = {1'b0, up_a[LO +: SW]} + {1'b0, eb_s[LO +: SW]} + {{SW{1'b0}}, up_carry};
    raw_s  = up_sum;
    raw_s[LO +: SW] = part_s[SW-1:0];
    if (LAST) begin
      ovf_s = signed_ovf(up_a[WIDTH-1], eb_s[WIDTH-1], raw_s[WIDTH-1]);
    end else begin
      ovf_s = 1'b0;
    end
    if (LAST && up_sat && ovf_s) begin
      sum_nx_s = up_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_nx_s = raw_s;
    end
  end

  // Stage register: load on transfer, empty when the beat leaves, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      sat_r   <= 1'b0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      a_r     <= up_a;
      b_r     <= up_b;
      sub_r   <= up_sub;
      sat_r   <= up_sat;
      sum_r   <= sum_nx_s;
      carry_r <= part_s[SW];
      ovf_r   <= ovf_s;
    end else if (dn_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign dn_valid = valid_r;
  assign dn_a     = a_r;
  assign dn_b     = b_r;
  assign dn_sub   = sub_r;
  assign dn_sat   = sat_r;
  assign dn_sum   = sum_r;
  assign dn_carry = carry_r;
  assign dn_ovf   = ovf_r;

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor with optional signed saturation. The carry
// chain is cut into STAGES equal slices, one per registered stage, with a
// valid/ready handshake that collapses bubbles.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be 8..64, STAGES 1..4, WIDTH divisible by STAGES");
  end

  // Index k feeds slice k; index k+1 is what slice k hands on.
  logic             v_s     [STAGES+1];
  logic             rdy_s   [STAGES+1];
  logic [WIDTH-1:0] a_s     [STAGES+1];
  logic [WIDTH-1:0] b_s     [STAGES+1];
  logic             sub_s   [STAGES+1];
  logic             sat_s   [STAGES+1];
  logic [WIDTH-1:0] sum_s   [STAGES+1];
  logic             carry_s [STAGES+1];
  logic             ovf_s   [STAGES];

  assign v_s[0]     = in_valid;
  assign a_s[0]     = a;
  assign b_s[0]     = b;
  assign sub_s[0]   = sub;
  assign sat_s[0]   = sat;
  assign sum_s[0]   = '0;
  assign carry_s[0] = sub;
  assign in_ready   = rdy_s[0];

  assign rdy_s[STAGES] = out_ready;
  assign out_valid     = v_s[STAGES];
  assign sum           = sum_s[STAGES];
  assign cout          = carry_s[STAGES];
  assign ovf           = ovf_s[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v_s[k]),
      .up_ready (rdy_s[k]),
      .up_a     (a_s[k]),
      .up_b     (b_s[k]),
      .up_sub   (sub_s[k]),
      .up_sat   (sat_s[k]),
      .up_sum   (sum_s[k]),
      .up_carry (carry_s[k]),
      .dn_valid (v_s[k+1]),
      .dn_ready (rdy_s[k+1]),
      .dn_a     (a_s[k+1]),
      .dn_b     (b_s[k+1]),
      .dn_sub   (sub_s[k+1]),
      .dn_sat   (sat_s[k+1]),
      .dn_sum   (sum_s[k+1]),
      .dn_carry (carry_s[k+1]),
      .dn_ovf   (ovf_s[k])
    );
  end

endmodule
